// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned JIDX_W      = 26;
    localparam int unsigned KIND_W      = 2;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10,
        ST_HALT    = 2'b11
    } fetch_state_e;

    typedef enum logic [KIND_W-1:0] {
        REDIR_BRANCH = 2'b00,
        REDIR_JUMP   = 2'b01,
        REDIR_JR     = 2'b10,
        REDIR_RSVD   = 2'b11
    } redir_kind_e;

    // Instruction word plus the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Redirect target selection: branch adder, jump concatenation, register target,
// plus a flag for targets that are not word aligned.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    input  logic [XLEN-1:0]   base,
    input  logic [XLEN-1:0]   sign_imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [XLEN-1:0]   jr_target,
    output logic [XLEN-1:0]   target_c,
    output logic              misaligned_c
);

    always_comb begin
        target_c = base + (sign_imm << 2);
        case (redir_kind_e'(kind))
            REDIR_JUMP: target_c = {base[XLEN-1:XLEN-4], jidx, 2'b00};
            REDIR_JR:   target_c = jr_target;
            default:    ;
        endcase
        misaligned_c = (target_c[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch with a one-entry decode buffer,
// control-flow redirects, and a sticky halt on misaligned targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redir_valid,
    input  logic [KIND_W-1:0] redir_kind,
    input  logic [XLEN-1:0]   sign_imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [XLEN-1:0]   jr_target,
    input  logic [XLEN-1:0]   redir_base,
    output logic              addr_err
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    fetch_pkt_t      pkt_q;
    logic [XLEN-1:0] redir_target;
    logic            redir_misaligned;
    logic            redir_take;
    logic            capture;

    next_pc_calc u_next_pc_calc (
        .kind         (redir_kind),
        .base         (redir_base),
        .sign_imm     (sign_imm),
        .jidx         (jidx),
        .jr_target    (jr_target),
        .target_c     (redir_target),
        .misaligned_c (redir_misaligned)
    );

    assign redir_take = redir_valid && (redir_kind_e'(redir_kind) != REDIR_RSVD)
                        && (state_q != ST_HALT);
    assign capture    = (state_q == ST_REQ) && imem_req && imem_ready;

    assign instr    = pkt_q.instr;
    assign instr_pc = pkt_q.pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a redirect that catches a request in flight must wait it out
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    state_d = ST_REQ;
            ST_REQ:     if (redir_take && imem_req && !imem_ready) state_d = ST_DISCARD;
            ST_DISCARD: if (imem_ready) state_d = ST_REQ;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase
        if (redir_take && redir_misaligned) begin
            state_d = ST_HALT;
        end
    end

    // Request strobe; a full, stalled buffer blocks a new fetch
    always_comb begin
        imem_req = 1'b0;
        unique case (state_q)
            ST_REQ:     imem_req = !instr_valid || instr_ready;
            ST_DISCARD: imem_req = 1'b1;
            default:    imem_req = 1'b0;
        endcase
    end

    // PC, request address and decode buffer; imem_addr tracks pc except in DISCARD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            imem_addr   <= RESET_PC;
            pkt_q       <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (state_q != ST_HALT) begin
            if (redir_take) begin
                pc_q        <= redir_target;
                instr_valid <= 1'b0;
                if (redir_misaligned) begin
                    addr_err <= 1'b1;
                end else if (state_d != ST_DISCARD) begin
                    imem_addr <= redir_target;
                end
            end else begin
                if (capture) begin
                    pkt_q       <= '{instr: imem_rdata, pc: pc_q};
                    instr_valid <= 1'b1;
                    pc_q        <= pc_q + XLEN'(INSTR_BYTES);
                    imem_addr   <= pc_q + XLEN'(INSTR_BYTES);
                end else if (instr_valid && instr_ready) begin
                    instr_valid <= 1'b0;
                end
                if ((state_q == ST_DISCARD) && imem_ready) begin
                    imem_addr <= pc_q;
                end
            end
        end
    end

endmodule
